// File: rtl/ber_checker_mc.sv
// Multi-channel self-synchronising PRBS bit-error-rate checker with per-channel lock/resync FSM.
// Optional macro ERR_INJECT_EN adds i_inject to invert a channel's decided bit for self-test.
module ber_checker_mc #(
   parameter int N_CH       = 2,
   parameter int NB_INPUT   = 8,
   parameter int PRBS_ORDER = 9,
   parameter int N_PHASES   = 4,
   parameter int NB_PHASE   = 2,
   parameter int N_WIN      = 128,
   parameter int LOCK_THR   = 8,
   parameter int NB_CNT     = 64
) (
   input  logic                     clk,
   input  logic                     i_rstn,
   input  logic                     i_en,
   input  logic                     i_valid,
   input  logic [NB_PHASE-1:0]      i_phase_sel,
   input  logic [N_CH*NB_INPUT-1:0] i_data,
   input  logic                     i_clear,
`ifdef ERR_INJECT_EN
   input  logic [N_CH-1:0]          i_inject,
`endif
   output logic [N_CH-1:0]          o_lock,
   output logic [N_CH*NB_CNT-1:0]   o_samp_cnt,
   output logic [N_CH*NB_CNT-1:0]   o_err_cnt,
   output logic [N_CH*8-1:0]        o_resync_cnt,
   output logic                     o_ber_zero
);

   localparam int PRBS_TAP = (PRBS_ORDER == 7)  ? 6  :
                             (PRBS_ORDER == 9)  ? 5  :
                             (PRBS_ORDER == 15) ? 14 : 1;
   localparam int SEED_W   = $clog2(PRBS_ORDER);
   localparam int WIN_W    = $clog2(N_WIN);
   localparam int WERR_W   = $clog2(N_WIN + 1);

   if (PRBS_ORDER != 7 && PRBS_ORDER != 9 && PRBS_ORDER != 15) begin : g_bad_order
      $error("ber_checker_mc: PRBS_ORDER must be 7, 9 or 15");
   end

   typedef enum logic {
      ST_SEED  = 1'b0,
      ST_CHECK = 1'b1
   } state_t;

   logic [NB_PHASE-1:0] phase_q;
   logic                sym;
   logic [N_CH-1:0]     err_zero;
   logic                ber_zero_q;
   logic                unused_data;

   // Only the sample MSBs carry decisions; the remaining bits are folded into one sink.
   assign unused_data = ^i_data;

   assign sym = i_valid & i_en & (phase_q == i_phase_sel);

   always_ff @(posedge clk) begin
      if (!i_rstn) begin
         phase_q <= '0;
      end else if (i_en && i_valid) begin
         if (phase_q == NB_PHASE'(N_PHASES - 1)) begin
            phase_q <= '0;
         end else begin
            phase_q <= phase_q + NB_PHASE'(1);
         end
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t                state_q;
      logic [PRBS_ORDER-1:0] hist_q;
      logic [SEED_W-1:0]     seed_cnt_q;
      logic [WIN_W-1:0]      win_cnt_q;
      logic [WERR_W-1:0]     win_err_q;
      logic [NB_CNT-1:0]     samp_cnt_q;
      logic [NB_CNT-1:0]     err_cnt_q;
      logic [7:0]            resync_cnt_q;
      logic                  bit_dec;
      logic                  pred;
      logic                  is_err;
      logic [WERR_W-1:0]     win_err_d;
      logic [NB_CNT-1:0]     samp_cnt_d;
      logic [NB_CNT-1:0]     err_cnt_d;
      logic [7:0]            resync_cnt_d;

`ifdef ERR_INJECT_EN
      assign bit_dec = i_data[gi*NB_INPUT + NB_INPUT - 1] ^ i_inject[gi];
`else
      assign bit_dec = i_data[gi*NB_INPUT + NB_INPUT - 1];
`endif

      // Newest bit sits in hist_q[0], so hist_q[i] is the bit i+1 symbols back.
      assign pred         = hist_q[PRBS_ORDER-1] ^ hist_q[PRBS_TAP-1];
      assign is_err       = bit_dec ^ pred;
      assign win_err_d    = win_err_q + WERR_W'(is_err);
      assign samp_cnt_d   = (&samp_cnt_q)   ? samp_cnt_q   : samp_cnt_q + NB_CNT'(1);
      assign err_cnt_d    = (&err_cnt_q)    ? err_cnt_q    : err_cnt_q + NB_CNT'(1);
      assign resync_cnt_d = (&resync_cnt_q) ? resync_cnt_q : resync_cnt_q + 8'd1;

      always_ff @(posedge clk) begin
         if (!i_rstn) begin
            state_q      <= ST_SEED;
            hist_q       <= '0;
            seed_cnt_q   <= '0;
            win_cnt_q    <= '0;
            win_err_q    <= '0;
            samp_cnt_q   <= '0;
            err_cnt_q    <= '0;
            resync_cnt_q <= '0;
         end else if (i_en) begin
            if (sym) begin
               case (state_q)
                  ST_SEED: begin
                     hist_q <= {hist_q[PRBS_ORDER-2:0], bit_dec};
                     if (seed_cnt_q == SEED_W'(PRBS_ORDER - 1)) begin
                        state_q   <= ST_CHECK;
                        win_cnt_q <= '0;
                        win_err_q <= '0;
                     end else begin
                        seed_cnt_q <= seed_cnt_q + SEED_W'(1);
                     end
                  end
                  ST_CHECK: begin
                     // Feeding back the prediction keeps one bad symbol from echoing at the taps.
                     hist_q     <= {hist_q[PRBS_ORDER-2:0], pred};
                     samp_cnt_q <= samp_cnt_d;
                     if (is_err) begin
                        err_cnt_q <= err_cnt_d;
                     end
                     if (win_cnt_q == WIN_W'(N_WIN - 1)) begin
                        win_cnt_q <= '0;
                        win_err_q <= '0;
                        if (win_err_d > WERR_W'(LOCK_THR)) begin
                           state_q      <= ST_SEED;
                           seed_cnt_q   <= '0;
                           resync_cnt_q <= resync_cnt_d;
                        end
                     end else begin
                        win_cnt_q <= win_cnt_q + WIN_W'(1);
                        win_err_q <= win_err_d;
                     end
                  end
                  default: state_q <= ST_SEED;
               endcase
            end
            if (i_clear) begin
               samp_cnt_q   <= '0;
               err_cnt_q    <= '0;
               resync_cnt_q <= '0;
            end
         end
      end

      assign o_lock[gi]                         = (state_q == ST_CHECK);
      assign err_zero[gi]                       = (err_cnt_q == '0);
      assign o_samp_cnt[gi*NB_CNT +: NB_CNT]    = samp_cnt_q;
      assign o_err_cnt[gi*NB_CNT +: NB_CNT]     = err_cnt_q;
      assign o_resync_cnt[gi*8 +: 8]            = resync_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!i_rstn) begin
         ber_zero_q <= 1'b0;
      end else begin
         ber_zero_q <= (&o_lock) & (&err_zero);
      end
   end

   assign o_ber_zero = ber_zero_q;

endmodule
